// File: rtl/fp_sub_sat_pipe.sv
// fp_sub_sat_pipe: two-stage pipelined signed fixed-point subtractor.
// Stage 1 forms the exact difference a - b at W_in+1 bits. Stage 2 rescales
// from W_in_F to W_out_F fractional bits, saturates to W_out bits and flags
// clamping. Valid/ready on both sides, two samples of buffering.
// Optional feature macro: FP_SUB_ROUND_EN (round half up on right shifts;
// when undefined, right shifts truncate toward -infinity).
module fp_sub_sat_pipe #(
  parameter int W_in    = 16,
  parameter int W_in_F  = 14,
  parameter int W_out   = 16,
  parameter int W_out_F = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_in-1:0]  a,
  input  logic [W_in-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_out-1:0] diff,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_sticky,
  output logic             sticky_ovf,
  output logic             sticky_unf
);

  localparam int SH  = W_in_F - W_out_F;
  localparam int ASH = (SH < 0) ? -SH : SH;
  localparam int WM  = (W_in + 1 > W_out) ? W_in + 1 : W_out;
  // One spare bit beyond the worst-case growth so rounding never wraps.
  localparam int WW  = WM + ASH + 1;

  localparam logic signed [WW-1:0] MAXV = {{(WW-W_out+1){1'b0}}, {(W_out-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(WW-W_out+1){1'b1}}, {(W_out-1){1'b0}}};

  logic             r_s1_valid;
  logic [W_in:0]    r_d1;
  logic             r_s2_valid;
  logic [W_out-1:0] r_diff;
  logic             r_ovf;
  logic             r_unf;
  logic             r_sticky_ovf;
  logic             r_sticky_unf;

  logic                 w_s2_adv;
  logic                 w_in_ready;
  logic                 w_out_xfer;
  logic signed [WW-1:0] w_ext;
  logic signed [WW-1:0] w_scaled;
  logic                 w_ovf;
  logic                 w_unf;
  logic [W_out-1:0]     w_sat;

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;
  assign w_out_xfer = r_s2_valid && out_ready;

  assign w_ext = {{(WW-W_in-1){r_d1[W_in]}}, r_d1};

  generate
    if (SH <= 0) begin : g_left
      // Gaining fractional bits is an exact left shift.
      assign w_scaled = w_ext <<< (-SH);
    end else begin : g_right
`ifdef FP_SUB_ROUND_EN
      localparam logic signed [WW-1:0] HALF = WW'(1) <<< (SH - 1);
      logic signed [WW-1:0] w_rnd;
      assign w_rnd    = w_ext + HALF;
      assign w_scaled = w_rnd >>> SH;
`else
      assign w_scaled = w_ext >>> SH;
`endif
    end
  endgenerate

  assign w_ovf = (w_scaled > MAXV);
  assign w_unf = (w_scaled < MINV);
  assign w_sat = w_ovf ? MAXV[W_out-1:0] :
                 w_unf ? MINV[W_out-1:0] : w_scaled[W_out-1:0];

  // Stage 1: capture the exact difference whenever the stage can take a sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_d1       <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_d1 <= {a[W_in-1], a} - {b[W_in-1], b};
    end
  end

  // Stage 2: rescale/saturate into the output register; holds under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_diff     <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_diff <= w_sat;
        r_ovf  <= w_ovf;
        r_unf  <= w_unf;
      end
    end
  end

  // Sticky flags: a delivered clamp sets them and wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky_ovf <= 1'b0;
      r_sticky_unf <= 1'b0;
    end else begin
      if (w_out_xfer && r_ovf) r_sticky_ovf <= 1'b1;
      else if (clear_sticky)   r_sticky_ovf <= 1'b0;
      if (w_out_xfer && r_unf) r_sticky_unf <= 1'b1;
      else if (clear_sticky)   r_sticky_unf <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_s2_valid;
  assign diff       = r_diff;
  assign overflow   = r_ovf;
  assign underflow  = r_unf;
  assign sticky_ovf = r_sticky_ovf;
  assign sticky_unf = r_sticky_unf;

endmodule

// File: tb/tb_fp_sub_sat_pipe.sv
// Bench for fp_sub_sat_pipe: a default instance (W_out_F=14) and a rescaling
// instance (W_out_F=12) share all inputs. Directed table, hand sequences for
// backpressure and reset, then random traffic against an integer model.
module tb_fp_sub_sat_pipe;

`ifdef FP_SUB_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clear_sticky = 1'b0;
  logic [15:0] a = '0, b = '0;

  logic        in_ready, out_valid, overflow, underflow, sticky_ovf, sticky_unf;
  logic [15:0] diff;
  logic        in_ready12, out_valid12, ovf12, unf12, sto12, stu12;
  logic [15:0] diff12;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_sub_sat_pipe u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .overflow(overflow), .underflow(underflow),
    .clear_sticky(clear_sticky), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf));

  fp_sub_sat_pipe #(.W_out_F(12)) u_dut12 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready12),
    .a(a), .b(b), .out_valid(out_valid12), .out_ready(out_ready),
    .diff(diff12), .overflow(ovf12), .underflow(unf12),
    .clear_sticky(clear_sticky), .sticky_ovf(sto12), .sticky_unf(stu12));

  typedef struct {
    logic [15:0] a, b, d0;
    logic        o0, u0;
    logic [15:0] d12t, d12r;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        o, u;
  } exp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: real-valued a-b scaled by 2^(W_out_F-W_in_F), floor or
  // round-half-up, then clamped to the signed 16-bit range.
  function automatic exp_t model(input int wof, input logic [15:0] ia, input logic [15:0] ib);
    exp_t   e;
    longint n, q, m;
    int     sh;
    n  = longint'($signed(ia)) - longint'($signed(ib));
    sh = 14 - wof;
    if (sh <= 0) begin
      n = n * (longint'(1) << (-sh));
    end else begin
      m = longint'(1) << sh;
      if (ROUND) n = n + m / 2;
      q = n / m;
      if ((n % m != 0) && (n < 0)) q = q - 1;
      n = q;
    end
    e.o = (n > 32767);
    e.u = (n < -32768);
    if (e.o)      e.d = 16'h7FFF;
    else if (e.u) e.d = 16'h8000;
    else          e.d = n[15:0];
    return e;
  endfunction

  vec_t tbl[7];
  exp_t q0[$];
  exp_t q12[$];

  initial begin
    exp_t e0, e12;
    logic st_o, st_u, st12_o, st12_u;
    logic xo;

    tbl[0] = '{16'h2000, 16'h1000, 16'h1000, 1'b0, 1'b0, 16'h0400, 16'h0400};
    tbl[1] = '{16'h6000, 16'hC000, 16'h7FFF, 1'b1, 1'b0, 16'h2800, 16'h2800};
    tbl[2] = '{16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 16'hDFFF, 16'hE000};
    tbl[3] = '{16'h0003, 16'h0000, 16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0001};
    tbl[4] = '{16'h0000, 16'h0002, 16'hFFFE, 1'b0, 1'b0, 16'hFFFF, 16'h0000};
    tbl[5] = '{16'h7FFF, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 16'h3FFF, 16'h4000};
    tbl[6] = '{16'h8000, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 16'hC000, 16'hC000};

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {overflow, underflow, sticky_ovf, sticky_unf}, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Directed table, one sample at a time with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b;
      #1;
      chk($sformatf("t%0d_in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("t%0d_lat1", i), out_valid, 0);
      tick();
      chk($sformatf("t%0d_lat2", i), out_valid, 1);
      chk($sformatf("t%0d_diff", i), diff, tbl[i].d0);
      chk($sformatf("t%0d_ovf_unf", i), {overflow, underflow}, {tbl[i].o0, tbl[i].u0});
      chk($sformatf("t%0d_diff12", i), diff12, ROUND ? tbl[i].d12r : tbl[i].d12t);
      chk($sformatf("t%0d_flags12", i), {ovf12, unf12}, 0);
      tick();
      chk($sformatf("t%0d_drain", i), out_valid, 0);
      chk($sformatf("t%0d_sticky", i), {sticky_ovf, sticky_unf}, {tbl[i].o0, tbl[i].u0});
      clear_sticky = 1'b1;
      tick();
      clear_sticky = 1'b0;
      chk($sformatf("t%0d_sticky_clr", i), {sticky_ovf, sticky_unf}, 0);
    end

    // Backpressure: three samples offered, two buffered, then in order
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h0100; b = 16'h0000;
    #1; chk("bp_rdy0", in_ready, 1);
    tick();
    a = 16'h0200;
    #1; chk("bp_rdy1", in_ready, 1);
    tick();
    a = 16'h0300;
    #1;
    chk("bp_rdy2", in_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_diff0", diff, 16'h0100);
    tick();
    chk("bp_stall_rdy", in_ready, 0);
    chk("bp_hold_diff1", diff, 16'h0100);
    tick();
    chk("bp_hold_diff2", diff, 16'h0100);
    out_ready = 1'b1;
    #1; chk("bp_rdy_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_out1_valid", out_valid, 1);
    chk("bp_out1", diff, 16'h0200);
    tick();
    chk("bp_out2_valid", out_valid, 1);
    chk("bp_out2", diff, 16'h0300);
    tick();
    chk("bp_empty", out_valid, 0);

    // Reset with two samples in flight and a pending overflow at the output
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h6000; b = 16'hC000;
    tick();
    tick();
    a = 16'h2000; b = 16'h1000;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("mr_pre_valid", out_valid, 1);
    chk("mr_pre_ovf", overflow, 1);
    chk("mr_pre_sticky", sticky_ovf, 1);
    reset = 1'b1;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_diff", diff, 0);
    chk("mr_flags", {overflow, underflow, sticky_ovf, sticky_unf}, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("mr_discard", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h2000; b = 16'h1000;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mr_new_valid", out_valid, 1);
    chk("mr_new_diff", diff, 16'h1000);
    chk("mr_new_flags", {overflow, underflow}, 0);
    tick();

    // Random traffic with a scoreboard and sticky model
    st_o = 0; st_u = 0; st12_o = 0; st12_u = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid     = ($urandom % 4) != 0;
      out_ready    = ($urandom % 4) != 0;
      clear_sticky = ($urandom % 8) == 0;
      a = 16'($urandom);
      b = 16'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL rnd_unexpected_output actual=%h expected=none", diff);
        end else begin
          e0 = q0.pop_front();
          e12 = q12.pop_front();
          chk("rnd_diff", diff, e0.d);
          chk("rnd_flags", {overflow, underflow}, {e0.o, e0.u});
          chk("rnd_diff12", diff12, e12.d);
          chk("rnd_flags12", {ovf12, unf12}, {e12.o, e12.u});
          xo = 1'b1;
          st_o   = e0.o  ? 1'b1 : (clear_sticky ? 1'b0 : st_o);
          st_u   = e0.u  ? 1'b1 : (clear_sticky ? 1'b0 : st_u);
          st12_o = e12.o ? 1'b1 : (clear_sticky ? 1'b0 : st12_o);
          st12_u = e12.u ? 1'b1 : (clear_sticky ? 1'b0 : st12_u);
        end
      end else begin
        xo = 1'b0;
      end
      if (!xo && clear_sticky) begin
        st_o = 0; st_u = 0; st12_o = 0; st12_u = 0;
      end
      if (in_valid && in_ready) begin
        q0.push_back(model(14, a, b));
        q12.push_back(model(12, a, b));
      end
      tick();
      chk("rnd_sticky", {sticky_ovf, sticky_unf}, {st_o, st_u});
      chk("rnd_sticky12", {sto12, stu12}, {st12_o, st12_u});
    end

    // Drain whatever is left, bounded
    in_valid = 1'b0; clear_sticky = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid && q0.size() != 0) begin
        e0 = q0.pop_front();
        e12 = q12.pop_front();
        chk("drain_diff", diff, e0.d);
        chk("drain_diff12", diff12, e12.d);
      end
      tick();
    end
    chk("drain_queue_empty", q0.size(), 0);
    chk("drain_out_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_sub_sat_pipe.md
Name: fp_sub_sat_pipe

Overview:
- Two-stage pipelined signed fixed-point subtractor, the complement of the team's registered fixed-point adder. Computes diff = a - b.
- Rescales the result from the input fractional format to the output fractional format.
- Saturates to the output range and flags overflow/underflow per sample.
- Valid/ready handshakes on both sides; sits in datapaths between the adder stages and downstream consumers that apply backpressure.

Parameters:
- W_in, 16, word length of a and b (two's complement).
- W_in_F, 14, fractional bits of a and b.
- W_out, 16, word length of diff.
- W_out_F, 14, fractional bits of diff.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  a/b are valid this cycle.
- in_ready  output  1  block accepts a/b this cycle.
- a  input  W_in  minuend, signed.
- b  input  W_in  subtrahend, signed.
- out_valid  output  1  diff and flags are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- diff  output  W_out  saturated, rescaled a - b, signed.
- overflow  output  1  this output was clamped to the maximum.
- underflow  output  1  this output was clamped to the minimum.
- clear_sticky  input  1  synchronous clear of the sticky flags.
- sticky_ovf  output  1  an overflow has been delivered since the last clear or reset.
- sticky_unf  output  1  an underflow has been delivered since the last clear or reset.

Behaviour:
Reset:
- Reset is asynchronous, active-high; the clock is clk.
- While reset is high: both stage valids = 0; diff = 0, overflow = 0, underflow = 0, out_valid = 0, sticky_ovf = 0, sticky_unf = 0.
- Reset mid-operation discards all in-flight samples.
- in_ready = 1 in the first cycle after reset deasserts.

Handshake:
- Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- s2_adv = !s2_valid | out_ready. in_ready = !s1_valid | s2_adv (combinational, no combinational path from in_valid).
- Latency: a sample accepted at edge N has out_valid = 1 after edge N+2 when out_ready is held high. Throughput is 1 sample per cycle.
- While out_valid = 1 and out_ready = 0, diff, overflow and underflow hold stable.
- Two samples can be buffered. No sample is lost or duplicated, and order is preserved.

Stage 1 (arithmetic):
- Register d1 = sign-extend(a) - sign-extend(b) at width W_in+1. This is exact; no wrap.

Stage 2 (rescale and saturate):
- Let sh = W_in_F - W_out_F.
- If sh <= 0: shift d1 left by -sh (exact).
- If sh > 0: arithmetic shift right by sh, rounded per the optional feature.
- Work at a width of at least max(W_in+1, W_out) + |sh| + 1 so no intermediate wraps.
- If the scaled value > 2^(W_out-1)-1: diff = 2^(W_out-1)-1, overflow = 1.
- If the scaled value < -2^(W_out-1): diff = -2^(W_out-1), underflow = 1.
- Otherwise diff = the scaled value, both flags = 0. overflow and underflow are never 1 together.
- Rounding that pushes the value past the maximum saturates and sets overflow.

Sticky flags:
- sticky_ovf/sticky_unf are set on an output transfer carrying overflow/underflow.
- clear_sticky clears them on the next edge.
- If clear_sticky and a setting transfer occur in the same cycle, the set wins.

Optional Feature:
- Macro: FP_SUB_ROUND_EN.
- Defined: when sh > 0, round half up. Add 2^(sh-1) before the arithmetic right shift.
- Undefined: truncate toward -infinity (plain arithmetic shift).
- With sh <= 0 the macro has no effect.

Test Plan:
- Defaults, out_ready = 1, a = 0x2000 (0.5), b = 0x1000 (0.25) -> diff = 0x1000, no flags, out_valid exactly 2 cycles after the input transfer.
- Defaults, a = 0x6000 (1.5), b = 0xC000 (-1.0) -> diff = 0x7FFF, overflow = 1, sticky_ovf = 1 after the transfer. Then clear_sticky -> sticky_ovf = 0.
- Defaults, a = 0x8000 (-2.0), b = 0x0001 -> diff = 0x8000, underflow = 1, overflow = 0.
- W_out_F = 12 instance, b = 0:
  - a = 0x0003 -> diff = 0x0001 with FP_SUB_ROUND_EN, 0x0000 without.
  - a = 0x0000, b = 0x0002 -> diff = 0x0000 with the macro, 0xFFFF without.
- Backpressure: out_ready = 0, offer 3 samples back-to-back -> only 2 accepted, then in_ready = 0 and diff stable. Raise out_ready -> all 3 delivered in order, no gaps once flowing.
- Assert reset with 2 samples in flight, including a pending overflow -> out_valid = 0, diff = 0, all flags = 0. After release, a new sample is processed normally.
